// File: rtl/rbb_pingpong_if.sv
// rbb_pingpong_if
//   Bundles the PE write side and the host read side of the result batch
//   buffer.
//   master : PE array / host side. Drives wr_en, wr_din, task_done, req_ack.
//   slave  : the buffer. Drives wr_ready, req_valid, req_line_idx, req_last,
//            rd_dout, batch_done, overflow.
interface rbb_pingpong_if #(
  parameter int WR_DATA_WIDTH = 32,
  parameter int RATIO         = 16,
  parameter int RD_ADDR_WIDTH = 8
);
  localparam int RD_DATA_WIDTH = WR_DATA_WIDTH * RATIO;

  logic                     wr_en;
  logic [WR_DATA_WIDTH-1:0] wr_din;
  logic                     wr_ready;
  logic                     task_done;
  logic                     req_valid;
  logic [RD_ADDR_WIDTH-1:0] req_line_idx;
  logic                     req_last;
  logic [RD_DATA_WIDTH-1:0] rd_dout;
  logic                     req_ack;
  logic                     batch_done;
  logic                     overflow;

  modport master (
    output wr_en, wr_din, task_done, req_ack,
    input  wr_ready, req_valid, req_line_idx, req_last, rd_dout,
           batch_done, overflow
  );

  modport slave (
    input  wr_en, wr_din, task_done, req_ack,
    output wr_ready, req_valid, req_line_idx, req_last, rd_dout,
           batch_done, overflow
  );
endinterface

// File: rtl/rbb_pingpong.sv
// rbb_pingpong
//   Double-buffered result batch buffer. PE result words are packed into
//   wide lines and written into one of two line banks while the host drains
//   the other bank line by line. A batch ends on task_done (flushing any
//   partial line) or when a bank fills up; batches are delivered strictly in
//   the order they were sealed.
// Ports
//   clk     : core clock
//   reset_n : synchronous, active-low reset (discards all buffered data)
//   bus     : rbb_pingpong_if.slave
//             write side  wr_en / wr_din / wr_ready / task_done / overflow
//             read side   req_valid / req_line_idx / req_last / rd_dout /
//                         req_ack / batch_done
module rbb_pingpong #(
  parameter int WR_DATA_WIDTH = 32,
  parameter int RATIO         = 16,
  parameter int RD_ADDR_WIDTH = 8
) (
  input logic           clk,
  input logic           reset_n,
  rbb_pingpong_if.slave bus
);
  localparam int RD_DATA_WIDTH = WR_DATA_WIDTH * RATIO;
  localparam int LANE_W        = $clog2(RATIO);
  localparam int DEPTH         = 2 ** RD_ADDR_WIDTH;
  localparam int CNT_W         = RD_ADDR_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, LOAD, PRESENT} rdState_t;

  // Both banks share one memory; the bank number is the address MSB.
  logic [RD_DATA_WIDTH-1:0] lineMem [2*DEPTH];

  logic [1:0]               bankSealed;
  logic [CNT_W-1:0]         lineCount [2];

  // Write side
  logic                     wrBank;
  logic [LANE_W-1:0]        laneIdx;
  logic [RD_ADDR_WIDTH-1:0] wrLine;
  logic [RD_DATA_WIDTH-1:0] lineBuf;
  logic [RD_DATA_WIDTH-1:0] mergedLine;
  logic                     overflowR;
  logic                     wrReady;
  logic                     wrAccept;
  logic                     lineLast;
  logic                     lineFull;
  logic                     flushLine;
  logic                     writeLine;
  logic                     autoSeal;
  logic                     doSeal;
  logic [CNT_W-1:0]         sealCount;

  // Seal hand-off to the bank state, one cycle behind the write side
  logic                     sealVld_p1;
  logic                     sealBank_p1;
  logic [CNT_W-1:0]         sealCount_p1;

  // Read side
  rdState_t                 state;
  rdState_t                 stateNxt;
  logic                     rdBank;
  logic [RD_ADDR_WIDTH-1:0] rdLine;
  logic                     loadStart;
  logic                     ackLine;
  logic                     relBank;
  logic                     isLast;
  logic                     reqValid;
  logic                     reqLast;
  logic [RD_ADDR_WIDTH-1:0] reqLineIdx;
  logic [RD_DATA_WIDTH-1:0] rdDout;
  logic                     batchDone;

  // ---------------------------------------------------------------------
  // Write side: packing and seal decision
  // ---------------------------------------------------------------------
  assign wrReady  = ~bankSealed[wrBank];
  assign wrAccept = bus.wr_en & wrReady;
  assign lineLast = (laneIdx == LANE_W'(RATIO - 1));
  assign lineFull = wrAccept & lineLast;

  // Lane 0 starts from a zero line, so stale lanes from the previous line
  // never leak into a flushed partial line and lineBuf needs no reset.
  always_comb begin
    mergedLine = (laneIdx == '0) ? '0 : lineBuf;
    if (wrAccept)
      mergedLine[laneIdx*WR_DATA_WIDTH +: WR_DATA_WIDTH] = bus.wr_din;
  end

  // A flush covers a word arriving with task_done as well as lanes already
  // held; a full line coinciding with task_done is one write, one seal.
  assign flushLine = bus.task_done & wrReady & (wrAccept | (laneIdx != '0));
  assign writeLine = lineFull | flushLine;
  assign sealCount = {1'b0, wrLine} + {{RD_ADDR_WIDTH{1'b0}}, writeLine};
  assign autoSeal  = lineFull & (wrLine == RD_ADDR_WIDTH'(DEPTH - 1));
  assign doSeal    = autoSeal | (bus.task_done & wrReady & (sealCount != '0));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wrBank       <= 1'b0;
      laneIdx      <= '0;
      wrLine       <= '0;
      overflowR    <= 1'b0;
      sealVld_p1   <= 1'b0;
      sealBank_p1  <= 1'b0;
      sealCount_p1 <= '0;
    end else begin
      sealVld_p1   <= doSeal;
      sealBank_p1  <= wrBank;
      sealCount_p1 <= sealCount;
      if (doSeal) begin
        wrBank  <= ~wrBank;
        laneIdx <= '0;
        wrLine  <= '0;
      end else if (wrAccept) begin
        laneIdx <= laneIdx + LANE_W'(1);
        if (lineLast)
          wrLine <= wrLine + RD_ADDR_WIDTH'(1);
      end
      if (bus.wr_en & ~wrReady)
        overflowR <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wrAccept)
      lineBuf <= mergedLine;
    if (writeLine)
      lineMem[{wrBank, wrLine}] <= mergedLine;
  end

  // ---------------------------------------------------------------------
  // Stage p1 -> bank state: seal becomes visible to the reader here
  // ---------------------------------------------------------------------
  // The sealing bank and the released bank can never be the same bank in
  // one cycle: one is not yet sealed, the other is sealed.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bankSealed   <= 2'b00;
      lineCount[0] <= '0;
      lineCount[1] <= '0;
    end else begin
      if (sealVld_p1) begin
        bankSealed[sealBank_p1] <= 1'b1;
        lineCount[sealBank_p1]  <= sealCount_p1;
      end
      if (relBank)
        bankSealed[rdBank] <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Read side FSM
  // ---------------------------------------------------------------------
  assign isLast = ({1'b0, rdLine} == (lineCount[rdBank] - CNT_W'(1)));

  always_comb begin
    stateNxt  = state;
    loadStart = 1'b0;
    ackLine   = 1'b0;
    relBank   = 1'b0;
    case (state)
      IDLE: begin
        if (bankSealed[rdBank]) begin
          stateNxt  = LOAD;
          loadStart = 1'b1;
        end
      end
      LOAD: stateNxt = PRESENT;
      PRESENT: begin
        if (bus.req_ack) begin
          if (reqLast) begin
            relBank  = 1'b1;
            stateNxt = IDLE;
          end else begin
            ackLine  = 1'b1;
            stateNxt = LOAD;
          end
        end
      end
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      rdBank     <= 1'b0;
      rdLine     <= '0;
      reqValid   <= 1'b0;
      reqLast    <= 1'b0;
      reqLineIdx <= '0;
      rdDout     <= '0;
      batchDone  <= 1'b0;
    end else begin
      state     <= stateNxt;
      batchDone <= relBank;
      if (loadStart)
        rdLine <= '0;
      if (ackLine)
        rdLine <= rdLine + RD_ADDR_WIDTH'(1);
      // rdDout doubles as the memory output register: one-cycle read.
      if (state == LOAD) begin
        rdDout     <= lineMem[{rdBank, rdLine}];
        reqLineIdx <= rdLine;
        reqLast    <= isLast;
        reqValid   <= 1'b1;
      end
      if (relBank | ackLine)
        reqValid <= 1'b0;
      if (relBank)
        rdBank <= ~rdBank;
    end
  end

  assign bus.wr_ready     = wrReady;
  assign bus.overflow     = overflowR;
  assign bus.req_valid    = reqValid;
  assign bus.req_line_idx = reqLineIdx;
  assign bus.req_last     = reqLast;
  assign bus.rd_dout      = rdDout;
  assign bus.batch_done   = batchDone;
endmodule

// File: tb/tb_rbb_pingpong.sv
// tb_rbb_pingpong
//   Directed bench for rbb_pingpong: drives PE words and task_done, plays
//   the host (acking lines) and compares every presented line against the
//   packing of the words that were sent.
module tb_rbb_pingpong;
  localparam int WDW   = 32;
  localparam int RATIO = 16;
  localparam int RAW   = 8;
  localparam int RDW   = WDW * RATIO;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  rbb_pingpong_if #(.WR_DATA_WIDTH(WDW), .RATIO(RATIO), .RD_ADDR_WIDTH(RAW)) bus ();

  rbb_pingpong #(.WR_DATA_WIDTH(WDW), .RATIO(RATIO), .RD_ADDR_WIDTH(RAW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int totalCnt = 0;
  int badCnt   = 0;

  task automatic checkVal(input string tag, input logic [RDW-1:0] obs,
                          input logic [RDW-1:0] exp);
    totalCnt++;
    if (obs !== exp) begin
      badCnt++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Line lineIdx of a batch whose words are base, base+1, ... (nWords long).
  function automatic logic [RDW-1:0] expLine(input int base, input int nWords,
                                             input int lineIdx);
    logic [RDW-1:0] l;
    l = '0;
    for (int j = 0; j < RATIO; j++) begin
      if (lineIdx * RATIO + j < nWords)
        l[j*WDW +: WDW] = WDW'(base + lineIdx * RATIO + j);
    end
    return l;
  endfunction

  task automatic writeWords(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      bus.wr_en  = 1'b1;
      bus.wr_din = WDW'(base + i);
      tick();
    end
    bus.wr_en = 1'b0;
  endtask

  task automatic sealBatch();
    bus.task_done = 1'b1;
    tick();
    bus.task_done = 1'b0;
  endtask

  task automatic waitValid(input string tag, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 40 && !ok; c++) begin
      if (bus.req_valid) ok = 1'b1;
      else tick();
    end
    if (!ok) checkVal({tag, " timeout"}, bus.req_valid, 1);
  endtask

  task automatic drainBatch(input int base, input int nWords, input int nLines,
                            input string tag);
    bit ok;
    for (int l = 0; l < nLines; l++) begin
      waitValid($sformatf("%s l%0d", tag, l), ok);
      if (!ok) return;
      checkVal($sformatf("%s l%0d idx", tag, l), bus.req_line_idx, l);
      checkVal($sformatf("%s l%0d last", tag, l), bus.req_last, (l == nLines - 1));
      checkVal($sformatf("%s l%0d data", tag, l), bus.rd_dout, expLine(base, nWords, l));
      bus.req_ack = 1'b1;
      tick();
      bus.req_ack = 1'b0;
      checkVal($sformatf("%s l%0d vdrop", tag, l), bus.req_valid, 0);
      checkVal($sformatf("%s l%0d bdone", tag, l), bus.batch_done, (l == nLines - 1));
    end
  endtask

  task automatic expectQuiet(input string tag);
    int seen;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      if (bus.req_valid) seen++;
      tick();
    end
    checkVal(tag, seen, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    bus.wr_en     = 1'b0;
    bus.wr_din    = '0;
    bus.task_done = 1'b0;
    bus.req_ack   = 1'b0;
    reset_n       = 1'b0;
    tick(); tick();

    // Reset state
    checkVal("rst wr_ready",  bus.wr_ready, 1);
    checkVal("rst req_valid", bus.req_valid, 0);
    checkVal("rst req_last",  bus.req_last, 0);
    checkVal("rst line_idx",  bus.req_line_idx, 0);
    checkVal("rst rd_dout",   bus.rd_dout, 0);
    checkVal("rst bdone",     bus.batch_done, 0);
    checkVal("rst overflow",  bus.overflow, 0);
    reset_n = 1'b1;
    tick();

    // Two full lines, latency from task_done
    writeWords(1, 32);
    sealBatch();
    checkVal("t1 lat e0", bus.req_valid, 0);
    tick();
    checkVal("t1 lat e1", bus.req_valid, 0);
    tick();
    checkVal("t1 lat e2", bus.req_valid, 0);
    tick();
    checkVal("t1 lat e3", bus.req_valid, 1);
    checkVal("t1 lane0",  bus.rd_dout[31:0], 32'h1);
    checkVal("t1 lane15", bus.rd_dout[511:480], 32'h10);
    drainBatch(1, 32, 2, "t1");

    // Partial line flush
    writeWords(32'h100, 5);
    sealBatch();
    drainBatch(32'h100, 5, 1, "t2");

    // task_done with nothing written, then task_done with the 16th word
    sealBatch();
    expectQuiet("t5 empty seal");
    checkVal("t5 wr_ready", bus.wr_ready, 1);
    writeWords(32'h600, 15);
    bus.wr_en     = 1'b1;
    bus.wr_din    = 32'h60F;
    bus.task_done = 1'b1;
    tick();
    bus.wr_en     = 1'b0;
    bus.task_done = 1'b0;
    drainBatch(32'h600, 16, 1, "t5");
    expectQuiet("t5 single batch");

    // Auto-seal of a full bank while bank 1 keeps filling
    writeWords(32'h1000, RATIO * (2 ** RAW));
    fork
      drainBatch(32'h1000, RATIO * (2 ** RAW), 2 ** RAW, "t3a");
      begin
        for (int i = 0; i < 32; i++) begin
          checkVal($sformatf("t3 rdy w%0d", i), bus.wr_ready, 1);
          bus.wr_en  = 1'b1;
          bus.wr_din = WDW'(32'h7000 + i);
          tick();
        end
        bus.wr_en = 1'b0;
        sealBatch();
      end
    join
    drainBatch(32'h7000, 32, 2, "t3b");

    // Both banks full, host stalled: back-pressure and overflow
    writeWords(32'h200, 16);
    sealBatch();
    writeWords(32'h300, 16);
    sealBatch();
    checkVal("t4 wr_ready low", bus.wr_ready, 0);
    bus.wr_en  = 1'b1;
    bus.wr_din = 32'hDEADBEEF;
    tick();
    bus.wr_en = 1'b0;
    checkVal("t4 overflow", bus.overflow, 1);
    sealBatch();
    drainBatch(32'h200, 16, 1, "t4a");
    checkVal("t4 wr_ready back", bus.wr_ready, 1);
    drainBatch(32'h300, 16, 1, "t4b");
    expectQuiet("t4 no extra batch");
    checkVal("t4 overflow sticky", bus.overflow, 1);

    // Reset in the middle of a batch
    writeWords(32'h400, 32);
    sealBatch();
    waitValid("t6 pre", ok);
    reset_n = 1'b0;
    tick();
    checkVal("t6 req_valid", bus.req_valid, 0);
    checkVal("t6 wr_ready",  bus.wr_ready, 1);
    checkVal("t6 overflow",  bus.overflow, 0);
    checkVal("t6 rd_dout",   bus.rd_dout, 0);
    reset_n = 1'b1;
    tick();
    writeWords(32'h500, 16);
    sealBatch();
    drainBatch(32'h500, 16, 1, "t6");
    expectQuiet("t6 old data gone");

    $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
    $finish;
  end
endmodule

// File: doc/rbb_pingpong.md
Name: rbb_pingpong

Overview:
- Double-buffered result batch buffer sitting between a PE array and the host write-back path.
- Packs narrow PE result words into wide cache lines, alternating between two BRAM banks.
- The PE array fills one bank while the host drains the other.
- Unlike the single-bank version, it drains only the lines actually written, flushes partial lines, applies write back-pressure, and tags the last line.

Parameters:
- WR_DATA_WIDTH, 32, width of one PE result word.
- RATIO, 16, words per line; RD_DATA_WIDTH = WR_DATA_WIDTH*RATIO (512); must be a power of 2, at least 2.
- RD_ADDR_WIDTH, 8, line address width per bank; DEPTH = 2**RD_ADDR_WIDTH lines per bank.

Ports:
- clk  in  1  core clock
- reset_n  in  1  synchronous active-low reset
- wr_en  in  1  PE word valid
- wr_din  in  WR_DATA_WIDTH  PE result word
- wr_ready  out  1  write bank can accept a word
- task_done  in  1  one-cycle pulse: current batch complete, seal bank
- req_valid  out  1  line presented to host
- req_line_idx  out  RD_ADDR_WIDTH  line index within batch
- req_last  out  1  presented line is last of batch
- rd_dout  out  RD_DATA_WIDTH  line data
- req_ack  in  1  host consumed presented line
- batch_done  out  1  one-cycle pulse when a bank is released
- overflow  out  1  sticky: word written while wr_ready=0

Behaviour:
- Reset:
  - Both banks empty, wr_bank=0, rd_bank=0, all counters 0.
  - Outputs: wr_ready=1, req_valid=0, req_last=0, req_line_idx=0, rd_dout=0, batch_done=0, overflow=0.
  - Reset mid-batch discards all buffered data.
- Bank state: each bank is FREE or SEALED and holds a line_count register of width RD_ADDR_WIDTH+1.
- wr_ready is 1 iff wr_bank is FREE.
- Packing:
  - wr_en && wr_ready stores wr_din in lane lane_idx; lane 0 occupies bits [WR_DATA_WIDTH-1:0].
  - lane_idx increments; when lane_idx==RATIO-1 the assembled line is written to BRAM at wr_line on the next edge, then wr_line increments and lane_idx returns to 0.
  - Lanes of a new line start at zero.
- Auto-seal: completing line DEPTH-1 seals the bank with line_count=DEPTH and toggles wr_bank.
- task_done handling:
  - Partial line pending (lane_idx!=0): the line is written with its unfilled lanes zero, and the bank seals with line_count=wr_line+1.
  - Otherwise the bank seals with line_count=wr_line.
  - line_count=0 (no words written): task_done is ignored and no batch is produced.
  - Seal takes effect at the edge after task_done is sampled. wr_bank toggles, lane_idx and wr_line clear.
- Simultaneous events:
  - wr_en and task_done in the same cycle: the word is included, then the bank seals.
  - task_done in the same cycle as an auto-seal: treated as a single seal, no empty batch.
- Back-pressure: wr_en while wr_ready=0 drops the word and sets overflow until reset. task_done while wr_ready=0 is ignored.
- Read FSM, states IDLE, LOAD, PRESENT:
  - IDLE: if rd_bank is SEALED, go to LOAD with line=0.
  - LOAD: drive BRAM raddr={rd_bank,line}; 1-cycle BRAM latency; at the next edge register the data into rd_dout, set req_line_idx=line and req_last=(line==line_count-1), assert req_valid, go to PRESENT.
  - PRESENT: rd_dout, req_line_idx and req_last are held stable until req_ack.
    - On req_ack when not last: req_valid=0, line+1, go to LOAD.
    - On req_ack when last: req_valid=0, mark bank FREE, pulse batch_done, toggle rd_bank, go to IDLE.
  - req_ack outside PRESENT is ignored.
- Timing:
  - Throughput is one line per 2 cycles.
  - With the read side idle, req_valid rises 3 edges after the edge that samples task_done.
- Release and refill: a bank freed at edge E may be written starting the cycle after E (wr_ready rises after E). A new seal of the other bank is independent of the drain in progress.
- Bank order is strict ping-pong: batches are delivered in the order they were sealed.

Test Plan:
- Reset, 32 words 0x1..0x20, task_done → 2 lines, first with lane0=0x1 and lane15=0x10; req_line_idx 0 then 1, req_last=1 on line 1, batch_done one cycle after the second ack, req_valid 3 edges after task_done.
- 5 words then task_done → single line with lanes 0-4 = data and lanes 5-15 = 0, req_last=1 on line 0.
- 16*DEPTH words with no task_done → auto-seal, 256 lines drained; writing of bank 1 continues uninterrupted and wr_ready stays 1.
- Fill both banks with the host not acking → wr_ready=0; the next wr_en sets overflow=1 and the word is absent from both batches; after the first batch_done, wr_ready=1.
- task_done with no words, and task_done in the same cycle as the 16th word → first produces no req_valid; second yields exactly 1 full line.
- Assert reset_n=0 while PRESENT is mid-batch → next cycle req_valid=0, wr_ready=1, overflow=0; a new 16-word batch drains as line 0.
